cdb_arbiter: RTL

- Round-robin arbiter for the common data bus (CDB) shared by the functional units and reservation stations.
- Each cycle it selects at most one requester with a completed result (tag + data) and registers it onto the CDB.
- The registered outputs drive the top level's cdb_data and the tag-match logic in the reservation stations and register file.
- Requesters that are not selected hold their result until granted.

---
 rtl/cdb_arbiter.sv | 105 ++++++++++
 1 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter for the common data bus.
// Picks at most one pending result per cycle (search starts at rr_ptr and
// wraps) and registers it onto the CDB one cycle later.
// Optional build macro: CDB_STALL_CNT_EN adds a saturating 16-bit stall_cnt
// output counting cycles in which some valid requester was left waiting.
module cdb_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 3,
    parameter int DATA_W  = 4,
    parameter int SRC_W   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      cdb_valid,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [DATA_W-1:0]         cdb_data,
    output logic [SRC_W-1:0]          cdb_src
`ifdef CDB_STALL_CNT_EN
    ,
    output logic [15:0]               stall_cnt
`endif
);

    logic [SRC_W-1:0] rr_ptr;
    logic [SRC_W-1:0] grant_idx;
    logic             grant_any;

    // Find the first valid requester at or after rr_ptr, wrapping; flush blocks the grant.
    always_comb begin
        int idx;
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!grant_any && req_valid[idx]) begin
                grant_any = 1'b1;
                grant_idx = SRC_W'(idx);
            end
        end
        if (flush) begin
            grant_any = 1'b0;
        end
    end

    // One-hot ready at the winning index.
    always_comb begin
        req_ready = '0;
        if (grant_any) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Pointer moves one past the winner; flush restarts the search at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (flush) begin
            rr_ptr <= '0;
        end else if (grant_any) begin
            if (grant_idx == SRC_W'(NUM_REQ - 1)) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= grant_idx + SRC_W'(1);
            end
        end
    end

    // Register the winner onto the bus; payload holds when nothing transfers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
            cdb_src   <= '0;
        end else if (grant_any) begin
            cdb_valid <= 1'b1;
            cdb_tag   <= req_tag[grant_idx*TAG_W +: TAG_W];
            cdb_data  <= req_data[grant_idx*DATA_W +: DATA_W];
            cdb_src   <= grant_idx;
        end else begin
            cdb_valid <= 1'b0;
        end
    end

`ifdef CDB_STALL_CNT_EN
    logic any_stall;
    assign any_stall = |(req_valid & ~req_ready);

    // Saturating count of cycles with a valid requester left waiting; only rst clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (any_stall && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule
